// File: rtl/dspl_rx.sv
// Seven-segment display scraper: rebuilds eight hex digits from a multiplexed anode/cathode drive.
// Captures land STABLE_CYCLES+1 samples after the 2-flop sync; digit outputs move only on frame commit.
module dspl_rx #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES   = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] dec_cat,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       frame_done,
    output logic       seg_err,
    output logic       an_err
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [7:0]    STAB_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    logic          rst_meta, rst_sync;
    logic [15:0]   smp_s1, smp, smp_prev;
    logic [7:0]    stab_cnt;
    logic [IW-1:0] idle_cnt;
    state_t        state, state_nxt;
    logic          eval;
    logic [7:0]    an_low;
    logic          one_low, multi_low;
    logic [2:0]    k;
    logic [4:0]    glyph;
    logic          cap, commit_cap, idle_hit, commit;
    logic          last_vld;
    logic [2:0]    last_idx;
    logic [7:0][5:0] shadow, shadow_nxt, dout;

    // Every other flop is released by rst_sync so they all leave reset on one edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = 5'h10;
            7'h30: decode = 5'h11;
            7'h6D: decode = 5'h12;
            7'h79: decode = 5'h13;
            7'h33: decode = 5'h14;
            7'h5B: decode = 5'h15;
            7'h5F: decode = 5'h16;
            7'h70: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h7B: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h1F: decode = 5'h1B;
            7'h4E: decode = 5'h1C;
            7'h3D: decode = 5'h1D;
            7'h4F: decode = 5'h1E;
            7'h47: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign an_low    = ~smp[15:8];
    assign one_low   = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
    assign multi_low = (an_low & (an_low - 8'd1)) != 8'd0;
    assign glyph     = decode(~smp[7:1]);

    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) k = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        eval      = 1'b0;
        if (smp != smp_prev) begin
            state_nxt = TRACK;
        end else if (state == TRACK && stab_cnt == STAB_MAX) begin
            eval      = 1'b1;
            state_nxt = HOLD;
        end
    end

    assign cap        = eval && one_low;
    assign commit_cap = cap && last_vld && (k <= last_idx);
    assign idle_hit   = !cap && (idle_cnt == IDLE_MAX);
    assign commit     = commit_cap || idle_hit;

    // A commit empties the shadow before the capture that caused it lands.
    always_comb begin
        shadow_nxt = commit ? '0 : shadow;
        if (cap && glyph[4]) shadow_nxt[k] = {1'b1, glyph[3:0], ~smp[0]};
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync) begin
            smp_s1     <= '1;
            smp        <= '1;
            smp_prev   <= '1;
            stab_cnt   <= '0;
            idle_cnt   <= '0;
            state      <= IDLE;
            last_vld   <= 1'b0;
            last_idx   <= '0;
            shadow     <= '0;
            dout       <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
        end else begin
            smp_s1     <= {an, dec_cat};
            smp        <= smp_s1;
            smp_prev   <= smp;
            state      <= state_nxt;
            shadow     <= shadow_nxt;
            frame_done <= commit;
            seg_err    <= cap && !glyph[4];
            an_err     <= eval && multi_low;
            if (smp != smp_prev)       stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 8'd1;
            if (cap || idle_hit) idle_cnt <= '0;
            else                 idle_cnt <= idle_cnt + 1'b1;
            if (commit) dout <= shadow;
            if (cap) begin
                last_vld <= 1'b1;
                last_idx <= k;
            end else if (idle_hit) begin
                last_vld <= 1'b0;
            end
        end
    end

    assign d1 = dout[0];
    assign d2 = dout[1];
    assign d3 = dout[2];
    assign d4 = dout[3];
    assign d5 = dout[4];
    assign d6 = dout[5];
    assign d7 = dout[6];
    assign d8 = dout[7];

endmodule

// File: doc/dspl_rx.md
DSPL_RX -- requirements
Module: dspl_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named `clock` and `reset`.
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the number of identical consecutive samples required before a digit is captured (legal range 2..255).
REQ-003 Parameter IDLE_CYCLES, default 1000000, SHALL set the number of cycles without a capture after which a blank frame is committed.
REQ-004 The port `clock` SHALL be an input, 1 bit wide: the system clock.
REQ-005 The port `reset` SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-006 The port `an` SHALL be an input, 8 bits wide: active-low anode selects; an[0] selects d1 and an[7] selects d8.
REQ-007 The port `dec_cat` SHALL be an input, 8 bits wide, active-low: dec_cat[7:1] are segments a..g and dec_cat[0] is dp.
REQ-008 The ports `d1`..`d8` SHALL be outputs, 6 bits wide each, with format {enable, hex[3:0], dp}, where dp=1 means the point is lit.
REQ-009 The port `frame_done` SHALL be an output, 1 bit wide: a one-cycle pulse on every frame commit.
REQ-010 The port `seg_err` SHALL be an output, 1 bit wide: a one-cycle pulse when a stable segment pattern is not a hex glyph.
REQ-011 The port `an_err` SHALL be an output, 1 bit wide: a one-cycle pulse when a stable sample has more than one anode low.

Function
REQ-012 `an` and `dec_cat` SHALL pass through a 2-flop synchronizer, giving 2 cycles of input latency; the result is the sample S.
REQ-013 The stability counter SHALL be handled as follows:
- It clears whenever S differs from the previous S.
- Otherwise it increments, saturating at STABLE_CYCLES-1.
REQ-014 The FSM SHALL have three states: IDLE (reset), TRACK and HOLD.
- Any change of S → TRACK.
- TRACK with counter = STABLE_CYCLES-1 → evaluate S → HOLD.
REQ-015 Evaluation of S SHALL depend on the number of low anode bits:
- Zero low: no action.
- More than one low: an_err pulse, no capture.
- Exactly one low (index k): capture.
REQ-016 On capture, a segment pattern SHALL be decoded as follows:
- A pattern matching one of the 16 hex glyphs (standard a..g shapes, lowercase b and d) writes shadow[k] <= {1, hex, ~dec_cat[0]}.
- Any other pattern pulses seg_err and leaves shadow[k] unchanged.
- All segments off is treated as the "any other pattern" case.
REQ-017 Frame boundary: a capture whose k ≤ the last captured index SHALL commit the frame, as follows:
- In the same cycle, d1..d8 <= shadow (before the new capture) and frame_done pulses.
- The shadow is then cleared to 0, and the new capture is written into the fresh shadow.
REQ-018 A seg_err capture SHALL still update the last captured index and SHALL still be able to trigger a commit.
REQ-019 Digits not captured during a frame SHALL commit as 6'b000000 (disabled).
REQ-020 The idle counter SHALL clear on every capture.
- When it reaches IDLE_CYCLES, the shadow is committed (stale digits read 0), frame_done pulses, the last index is invalidated and the counter clears.
REQ-021 Outputs `d1`..`d8` SHALL change only on a commit; `frame_done`, `seg_err` and `an_err` SHALL be registered single-cycle pulses.

Reset
REQ-022 Asserting reset low SHALL take effect asynchronously and set the following:
- Synchronizer flops to 1 (inactive).
- d1..d8 = 0; frame_done = seg_err = an_err = 0.
- FSM = IDLE; counters = 0; shadow = 0; last index invalid.
REQ-023 A reset asserted mid-frame SHALL discard the partial shadow; the first capture after release SHALL NOT commit.
REQ-024 Reset release SHALL be synchronized internally so that all state leaves reset on the same clock edge.

Verification
REQ-025 The bench SHALL drive an=8'hFE, dec_cat=8'b0000_0011 for 8 cycles, then an=8'hFD, dec_cat=8'b1001_1111 for 8 cycles, then an=8'hFE again for 8 cycles.
- Required: frame_done pulses once; d1=6'b1_0000_0, d2=6'b1_0001_0, d3..d8=0.
REQ-026 The bench SHALL hold an=8'h7F, dec_cat=8'b0001_0000 (A with dp lit), then let the scan wrap.
- Required: d8=6'b1_1010_1.
REQ-027 The bench SHALL toggle dec_cat every 2 cycles while an=8'hFE, with STABLE_CYCLES=4.
- Required: no capture, no pulses.
REQ-028 The bench SHALL make one stable sample with an=8'hFC.
- Required: an_err pulses once, shadow unchanged.
- The bench SHALL then make one stable sample with dec_cat=8'b1111_1111 (all segments off).
- Required: seg_err pulses once, shadow unchanged.
REQ-029 After a committed frame with d1=F (dec_cat=8'b0111_0001), the bench SHALL hold an=8'hFF for IDLE_CYCLES cycles (set IDLE_CYCLES=64).
- Required: frame_done pulses; d1..d8 are unchanged from the committed frame.
- The bench SHALL then hold an=8'hFF for a further 64 cycles.
- Required: frame_done pulses again; d1..d8=0.
REQ-030 The bench SHALL assert reset mid-frame after d3=5 (dec_cat=8'b0100_1001) is captured.
- Required: all outputs 0 immediately.
- After release, a single digit-1 capture SHALL NOT pulse frame_done.
